regfile_stream_loader: RTL and testbench
========================================

Name: regfile_stream_loader

Overview:
- Initiator-side block for the 32x32 register file's write port and rs1 read port.
- Bulk-loads a contiguous register range from a valid/ready input stream, or dumps a range to a valid/ready output stream.
- Used to preload CNN weights and constants into the register file, and to read results back for host/debug.
- Sits between the host stream fabric and the register file; its write and read ports connect directly to the file's rd/writedata/regwrite and rs1/readdata1.

Parameters:
- DATA_W, 32, register word width.
- ADDR_W, 5, register index width (file depth = 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = LOAD, 1 = DUMP.
- cmd_base  in  ADDR_W  first register index.
- cmd_count  in  ADDR_W+1  number of registers, 0..32.
- in_valid  in  1  load data valid.
- in_ready  out  1  load data accepted.
- in_data  in  DATA_W  load word.
- out_valid  out  1  dump word valid.
- out_ready  in  1  dump consumer ready.
- out_data  out  DATA_W  dump word.
- rd  out  ADDR_W  to register file write index.
- writedata  out  DATA_W  to register file write data.
- regwrite  out  1  to register file write enable.
- rs1  out  ADDR_W  to register file read index.
- readdata1  in  DATA_W  from register file (combinational read).
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at end of command.

Behaviour:
- Reset: synchronous, active-high, on the clk rising edge.
- Values on reset:
  - state = IDLE.
  - cmd_ready = 1.
  - in_ready, out_valid, regwrite, busy, done = 0.
  - out_data = 0.
  - rd, rs1 = 0.
  - writedata = 0.
  - addr and remaining counters = 0.
- Reset mid-command aborts it immediately. No further regwrite is issued after the reset edge. Partially loaded registers keep their written values.
- States: IDLE, LOAD, DUMP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr = cmd_base and rem = cmd_count.
  - If cmd_count == 0, go to DONE. Otherwise go to LOAD or DUMP per cmd_op.
- LOAD:
  - in_ready = 1.
  - regwrite = in_valid (combinational); rd = addr; writedata = in_data.
  - On each in_valid handshake, the write commits at that edge, addr increments and rem decrements.
  - When the handshake with rem == 1 occurs, go to DONE.
  - Writes to index 0 are still issued; the register file discards them, so they are not blocked here.
- DUMP:
  - rs1 = addr; regwrite = 0.
  - out_data is registered. out_data <= readdata1 and out_valid <= 1 whenever (!out_valid || out_ready) and words remain to fetch; addr then increments.
  - out_valid and out_data are held stable while out_valid && !out_ready.
  - First out_valid rises 1 cycle after entering DUMP. With out_ready held high, throughput is 1 word/cycle.
  - Go to DONE on the handshake of the final word; out_valid is 0 in DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Address wrap: addr increments modulo 2**ADDR_W. base=30, count=4 accesses 30, 31, 0, 1.
- count = 32 covers the whole file once.
- cmd_valid is ignored while busy; no queuing.
- in_valid is ignored outside LOAD. out_ready has no effect while out_valid = 0.

Optional Feature:
- Macro: REGFILE_STREAM_CHECKSUM_EN.
- When defined:
  - Adds output port checksum[DATA_W-1:0].
  - checksum clears to 0 on command acceptance and on rst.
  - It XOR-accumulates every word transferred: each LOAD handshake word, and each DUMP word at its out handshake.
  - Value is stable from the done pulse until the next command.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- LOAD base=4, count=3, words 0xA, 0xB, 0xC with in_valid continuous -> regwrite high for 3 cycles, rd = 4, 5, 6; done pulses 1 cycle after the 3rd; regs 4..6 hold 0xA..0xC.
- DUMP base=4, count=3 after the load, out_ready=1 -> out_valid from cycle 1, out_data 0xA, 0xB, 0xC on consecutive cycles; done follows.
- DUMP with out_ready toggled 1,0,0,1,... -> out_data never changes while stalled; no words dropped or duplicated.
- LOAD base=30, count=4, words 1..4 -> rd = 30, 31, 0, 1. A subsequent DUMP base=30, count=4 returns 1, 2, 0, 4 (register 0 reads 0).
- cmd_count=0 -> done pulses on the cycle after acceptance; no regwrite and no out_valid. A second cmd_valid while busy is not accepted.
- rst asserted after 2 of 5 LOAD words -> next cycle: regwrite=0, busy=0, cmd_ready=1; registers base and base+1 are written, the rest untouched. With REGFILE_STREAM_CHECKSUM_EN, checksum=0.

Source files
------------

// File: rtl/regfile_stream_loader.sv
// Streams a contiguous register range into (LOAD) or out of (DUMP) the register file.
// Optional XOR checksum of transferred words when REGFILE_STREAM_CHECKSUM_EN is defined.
module regfile_stream_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef REGFILE_STREAM_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writedata,
    output logic              regwrite,
    output logic [ADDR_W-1:0] rs1,
    input  logic [DATA_W-1:0] readdata1,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StLoad, StDump, StDone} state_e;

    localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    rem_q, rem_d;      // words still to deliver/accept
    logic [ADDR_W:0]    fetch_q, fetch_d;  // DUMP words still to read from the file
    logic               ov_q, ov_d;
    logic [DATA_W-1:0]  od_q, od_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            fetch_q <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            fetch_q <= fetch_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        fetch_d   = fetch_q;
        ov_d      = ov_q;
        od_d      = od_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        regwrite  = 1'b0;
        writedata = '0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    addr_d  = cmd_base;
                    rem_d   = cmd_count;
                    fetch_d = cmd_count;
                    if (cmd_count == '0) state_d = StDone;
                    else if (cmd_op)     state_d = StDump;
                    else                 state_d = StLoad;
                end
            end
            StLoad: begin
                in_ready  = 1'b1;
                regwrite  = in_valid;
                writedata = in_data;
                if (in_valid) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == CntOne) state_d = StDone;
                end
            end
            StDump: begin
                if (ov_q && out_ready) begin
                    ov_d  = 1'b0;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CntOne) state_d = StDone;
                end
                // Refill the output register whenever it is empty or being drained.
                if ((!ov_q || out_ready) && fetch_q != '0) begin
                    od_d    = readdata1;
                    ov_d    = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    fetch_d = fetch_q - 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd        = addr_q;
    assign rs1       = addr_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;

`ifdef REGFILE_STREAM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (state_q == StIdle && cmd_valid) begin
            checksum <= '0;
        end else if (state_q == StLoad && in_valid) begin
            checksum <= checksum ^ in_data;
        end else if (state_q == StDump && ov_q && out_ready) begin
            checksum <= checksum ^ od_q;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_stream_loader.sv
// Directed bench for regfile_stream_loader with a behavioural 32x32 register file attached.
module tb_regfile_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [4:0]  cmd_base;
    logic [5:0]  cmd_count;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  rd, rs1;
    logic [31:0] writedata, readdata1;
    logic        regwrite, busy, done;
`ifdef REGFILE_STREAM_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    regfile_stream_loader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef REGFILE_STREAM_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .rs1       (rs1),
        .readdata1 (readdata1),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Register file: index 0 is hardwired to zero.
    logic [31:0] rf [32];
    logic        rf_clr;
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwrite && rd != 5'd0) begin
            rf[rd] <= writedata;
        end
    end
    assign readdata1 = rf[rs1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        cv;
        logic        op;
        logic [4:0]  base;
        logic [5:0]  cnt;
        logic        iv;
        logic [31:0] idata;
        logic        ordy;
        logic        e_cr;
        logic        e_busy;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic        e_done;
        logic        e_ov;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs [12];

    logic [31:0] got [8];
    int          n;

    task automatic run_dump(input logic [4:0] b, input logic [5:0] c, input bit stall);
        logic        p_ov, p_rdy;
        logic [31:0] p_od;
        p_ov = 1'b0; p_rdy = 1'b0; p_od = '0;
        n = 0;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = b; cmd_count = c;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 40 && n < int'(c); k++) begin
            out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (p_ov && !p_rdy) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_data", out_data, p_od);
            end
            if (out_valid && out_ready) begin
                got[n] = out_data;
                n++;
            end
            p_ov = out_valid; p_rdy = out_ready; p_od = out_data;
            cyc();
        end
        chk("dump_count", n, int'(c));
        @(negedge clk);
        chk("dump_done", {31'b0, done}, 32'd1);
        chk("dump_done_ov", {31'b0, out_valid}, 32'd0);
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 5'd4, 6'd3, 1'b0, 32'h0, 1'b0,  1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 32'hA, 1'b0,  1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 32'hB, 1'b0,  1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 32'hC, 1'b0,  1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b0,  1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 5'd4, 6'd3, 1'b0, 32'h0, 1'b1,  1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hA};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hB};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hC};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0, 1'b0,  1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0};

        rst = 1'b1; rf_clr = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_regwrite", {31'b0, regwrite}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rd", {27'b0, rd}, 32'd0);
        chk("rst_rs1", {27'b0, rs1}, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        cyc();
        rst = 1'b0; rf_clr = 1'b0;

        // LOAD 4..6 then DUMP 4..6, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            cmd_valid = vecs[i].cv; cmd_op = vecs[i].op;
            cmd_base = vecs[i].base; cmd_count = vecs[i].cnt;
            in_valid = vecs[i].iv; in_data = vecs[i].idata; out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_cmd_ready", i), {31'b0, cmd_ready}, {31'b0, vecs[i].e_cr});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
            chk($sformatf("v%0d_regwrite", i), {31'b0, regwrite}, {31'b0, vecs[i].e_rw});
            chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, vecs[i].e_done});
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            if (vecs[i].e_rw) begin
                chk($sformatf("v%0d_rd", i), {27'b0, rd}, {27'b0, vecs[i].e_rd});
                chk($sformatf("v%0d_writedata", i), writedata, vecs[i].idata);
            end
            if (vecs[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
            cyc();
        end
        cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("rf4", rf[4], 32'hA);
        chk("rf5", rf[5], 32'hB);
        chk("rf6", rf[6], 32'hC);
`ifdef REGFILE_STREAM_CHECKSUM_EN
        chk("checksum_dump", checksum, 32'hD);
`endif

        // Stalled dump: out_ready pattern 1,0,0,1,...
        run_dump(5'd4, 6'd3, 1'b1);
        chk("stall_w0", got[0], 32'hA);
        chk("stall_w1", got[1], 32'hB);
        chk("stall_w2", got[2], 32'hC);

        // Wrapping load 30,31,0,1.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 5'd30; cmd_count = 6'd4;
        cyc();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] exp_rd;
            exp_rd = 5'(30 + i);
            in_valid = 1'b1; in_data = 32'(i + 1);
            @(negedge clk);
            chk($sformatf("wrap_rw%0d", i), {31'b0, regwrite}, 32'd1);
            chk($sformatf("wrap_rd%0d", i), {27'b0, rd}, {27'b0, exp_rd});
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_done", {31'b0, done}, 32'd1);
        cyc();
        run_dump(5'd30, 6'd4, 1'b0);
        chk("wrap_w0", got[0], 32'd1);
        chk("wrap_w1", got[1], 32'd2);
        chk("wrap_w2", got[2], 32'd0);
        chk("wrap_w3", got[3], 32'd4);

        // Zero-count command, plus a second command offered while busy.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 5'd3; cmd_count = 6'd0;
        @(negedge clk);
        chk("zero_accept", {31'b0, cmd_ready}, 32'd1);
        cyc();
        cmd_count = 6'd3;
        @(negedge clk);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("zero_regwrite", {31'b0, regwrite}, 32'd0);
        chk("zero_out_valid", {31'b0, out_valid}, 32'd0);
        cyc();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("zero_not_taken", {31'b0, busy}, 32'd0);
        chk("zero_done_once", {31'b0, done}, 32'd0);
        cyc();

        // Reset after two of five LOAD words.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 5'd10; cmd_count = 6'd5;
        cyc();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_data = 32'h1111; cyc();
        in_data = 32'h2222; cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h3333;
        @(negedge clk);
        chk("abort_regwrite", {31'b0, regwrite}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
`ifdef REGFILE_STREAM_CHECKSUM_EN
        chk("abort_checksum", checksum, 32'd0);
`endif
        cyc();
        in_valid = 1'b0;
        chk("abort_rf10", rf[10], 32'h1111);
        chk("abort_rf11", rf[11], 32'h2222);
        chk("abort_rf12", rf[12], 32'h0);
        chk("abort_rf13", rf[13], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
